alu_instr_sequencer: RTL

Program sequencer that sits directly upstream of the accumulator ALU CPU and drives its `instruction`, `DataInput` and `new_instruction` inputs. A host preloads a small program memory of {opcode, operand} entries, then pulses `start`. The sequencer issues each entry to the CPU as a one-cycle `new_instruction` pulse and waits for the CPU's `ready` before issuing the next. It replaces hand-timed stimulus with a handshake-correct feeder.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_prog_mem.sv | 33 +++
 rtl/alu_instr_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcode values,
// FSM state encoding and the width of one program-memory entry.
package alu_seq_pkg;

  // One program entry is {opcode[2:0], operand[15:0]}
  localparam int ENTRY_W = 19;

  // Opcodes understood by the downstream accumulator ALU CPU
  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_ISSUE      = 3'd2,
    S_SETTLE     = 3'd3,
    S_WAIT_READY = 3'd4,
    S_DONE       = 3'd5
  } seq_state_t;

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program memory for the sequencer: DEPTH x ENTRY_W register array with
// one write port and a registered read port. The array itself is not reset;
// only the read register is, so the CPU-facing outputs start at zero.
module alu_seq_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write port: host loads program entries
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: value is captured only on a fetch and held until the next one
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Program sequencer feeding the accumulator ALU CPU. Issues each stored
// {opcode, operand} as a one-cycle new_instruction strobe and waits for
// cpu_ready before moving on. Optional ready-wait timeout is enabled by
// defining the macro ALU_SEQ_TIMEOUT_EN.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [2:0]        load_instr,
  input  logic [15:0]       load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              cpu_ready,
  output logic [2:0]        instruction,
  output logic [15:0]       cpu_data,
  output logic              new_instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  seq_state_t         state, state_nxt;
  logic [ADDR_W:0]    len;
  logic [ADDR_W:0]    len_in;
  logic [ENTRY_W-1:0] rdata;
  logic               start_ok;
  logic               last_entry;
  logic               tmo_hit;

  // Run length is clamped to the memory size so pc can never wrap
  assign len_in     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign start_ok   = (state == S_IDLE) && start && !abort;
  assign last_entry = ({1'b0, pc} == (len - ONE_L));

  alu_seq_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (load_en && !busy),
    .waddr (load_addr),
    .wdata ({load_instr, load_data}),
    .re    (state == S_FETCH),
    .raddr (pc),
    .rdata (rdata)
  );

  // The fetched entry appears in ISSUE and stays until the next fetch lands
  assign instruction = rdata[ENTRY_W-1:16];
  assign cpu_data    = rdata[15:0];

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_flag;

  assign tmo_hit     = (state == S_WAIT_READY) && !cpu_ready &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout_err = tmo_flag;

  // Count consecutive not-ready cycles; zero whenever outside WAIT_READY
  always_ff @(posedge clk) begin
    if (rst)                          wait_cnt <= '0;
    else if (state != S_WAIT_READY)   wait_cnt <= '0;
    else if (!cpu_ready)              wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Sticky error flag, cleared only by reset or a newly accepted run
  always_ff @(posedge clk) begin
    if (rst)                   tmo_flag <= 1'b0;
    else if (start_ok)         tmo_flag <= 1'b0;
    else if (tmo_hit && !abort) tmo_flag <= 1'b1;
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe outputs; abort overrides everything outside IDLE
  always_comb begin
    state_nxt       = state;
    new_instruction = 1'b0;
    done            = 1'b0;
    busy            = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = (len_in == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH:  state_nxt = S_ISSUE;
      S_ISSUE: begin
        new_instruction = 1'b1;
        state_nxt       = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_WAIT_READY;
      S_WAIT_READY: begin
        if (cpu_ready)    state_nxt = last_entry ? S_DONE : S_FETCH;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nxt       = S_IDLE;
      new_instruction = 1'b0;
      done            = 1'b0;
    end
  end

  // Program counter and latched run length
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      len <= '0;
    end else if (start_ok) begin
      pc  <= '0;
      len <= len_in;
    end else if ((state == S_WAIT_READY) && cpu_ready && !last_entry && !abort) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule
